jtvigil_snd_arb: RTL and testbench

- Shares one SDRAM bank between the sound CPU ROM port and the PCM sample ROM port of the Vigilante core.
- Each requester gets a one-word (16-bit) cache, a registered ok flag and 8-bit byte selection.
- Misses are serialised onto the bank read handshake with round-robin priority.
- Sits between jtvigil_snd and the SDRAM bank signals inside the core's SDRAM wrapper.

---
 rtl/jtvigil_snd_arb.sv | 145 ++++++++++++++
 tb/tb_jtvigil_snd_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtvigil_snd_arb.sv
// Arbitrates the sound CPU ROM and PCM ROM ports onto one SDRAM bank.
// Each port has a one-word cache; misses are served round-robin over the bank handshake.
module jtvigil_snd_arb #(
    parameter logic [21:0] PCM_OFFSET = 22'h08000,
    parameter logic [21:0] SND_OFFSET = 22'h00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic        snd_cs,
    input  logic [15:0] snd_addr,
    output logic [7:0]  snd_data,
    output logic        snd_ok,
    input  logic        pcm_cs,
    input  logic [15:0] pcm_addr,
    output logic [7:0]  pcm_data,
    output logic        pcm_ok,
    output logic [21:0] ba_addr,
    output logic        ba_rd,
    input  logic        ba_ack,
    input  logic        ba_rdy,
    input  logic [15:0] data_read
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_ACK = 2'd1;
    localparam logic [1:0] WAIT_RDY = 2'd2;

    // Requester index 0 is the sound CPU, 1 is the PCM port
    logic [1:0]  cs_v;
    logic [15:0] addr_v [2];
    logic [1:0]  valid;
    logic [14:0] tag    [2];
    logic [15:0] word   [2];
    logic [1:0]  hit;
    logic [1:0]  miss;
    logic [1:0]  ok_v;
    logic [7:0]  data_v [2];

    logic [1:0]  state;
    logic        sel;
    logic        last_served;
    logic [14:0] req_tag;
    logic        discard;
    logic        fill;
    logic        keep;
    logic        pick_pcm;
    logic [14:0] pick_tag;
    logic [21:0] pick_offset;

    assign cs_v      = {pcm_cs, snd_cs};
    assign addr_v[0] = snd_addr;
    assign addr_v[1] = pcm_addr;

    always_comb begin
        hit  = 2'b00;
        miss = 2'b00;
        for (int i = 0; i < 2; i++) begin
            hit[i]  = cs_v[i] & valid[i] & (tag[i] == addr_v[i][15:1]);
            miss[i] = cs_v[i] & ~hit[i];
        end
    end

    // On a tie the requester that was not served last wins
    assign pick_pcm    = miss[1] & (~miss[0] | ~last_served);
    assign pick_tag    = pick_pcm ? pcm_addr[15:1] : snd_addr[15:1];
    assign pick_offset = pick_pcm ? PCM_OFFSET : SND_OFFSET;

    // ack and rdy together in WAIT_ACK count as ack followed by rdy
    assign fill = ((state == WAIT_ACK) & ba_ack & ba_rdy) | ((state == WAIT_RDY) & ba_rdy);
    assign keep = ~downloading & ~discard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ba_rd       <= 1'b0;
            ba_addr     <= 22'd0;
            sel         <= 1'b0;
            req_tag     <= 15'd0;
            last_served <= 1'b1;
            discard     <= 1'b0;
        end else begin
            if (downloading && state != IDLE) begin
                discard <= 1'b1;
            end
            if (fill) begin
                last_served <= sel;
            end
            case (state)
                IDLE: begin
                    if (!downloading && miss != 2'b00) begin
                        sel     <= pick_pcm;
                        req_tag <= pick_tag;
                        ba_rd   <= 1'b1;
                        ba_addr <= pick_offset + {7'd0, pick_tag};
                        discard <= 1'b0;
                        state   <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ba_ack) begin
                        ba_rd <= 1'b0;
                        state <= ba_rdy ? IDLE : WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (ba_rdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                valid[i]  <= 1'b0;
                tag[i]    <= 15'd0;
                word[i]   <= 16'd0;
                ok_v[i]   <= 1'b0;
                data_v[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                ok_v[i]   <= hit[i] & ~downloading;
                data_v[i] <= addr_v[i][0] ? word[i][15:8] : word[i][7:0];
                if (fill && sel == 1'(i)) begin
                    word[i]  <= data_read;
                    tag[i]   <= req_tag;
                    valid[i] <= keep;
                end else if (downloading) begin
                    valid[i] <= 1'b0;
                end
            end
        end
    end

    assign snd_ok   = ok_v[0];
    assign pcm_ok   = ok_v[1];
    assign snd_data = data_v[0];
    assign pcm_data = data_v[1];

endmodule

// File: tb/tb_jtvigil_snd_arb.sv
// Directed bench for jtvigil_snd_arb: hand-written miss/arbitration sequences plus a table of cache hit vectors.
module tb_jtvigil_snd_arb;

    logic        clk;
    logic        rst;
    logic        downloading;
    logic        snd_cs;
    logic [15:0] snd_addr;
    logic [7:0]  snd_data;
    logic        snd_ok;
    logic        pcm_cs;
    logic [15:0] pcm_addr;
    logic [7:0]  pcm_data;
    logic        pcm_ok;
    logic [21:0] ba_addr;
    logic        ba_rd;
    logic        ba_ack;
    logic        ba_rdy;
    logic [15:0] data_read;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        snd_cs;
        logic [15:0] snd_addr;
        logic        pcm_cs;
        logic [15:0] pcm_addr;
        logic        exp_snd_ok;
        logic [7:0]  exp_snd_data;
        logic        exp_pcm_ok;
        logic [7:0]  exp_pcm_data;
    } vec_t;

    vec_t vecs [6];

    jtvigil_snd_arb dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .snd_cs      (snd_cs),
        .snd_addr    (snd_addr),
        .snd_data    (snd_data),
        .snd_ok      (snd_ok),
        .pcm_cs      (pcm_cs),
        .pcm_addr    (pcm_addr),
        .pcm_data    (pcm_data),
        .pcm_ok      (pcm_ok),
        .ba_addr     (ba_addr),
        .ba_rd       (ba_rd),
        .ba_ack      (ba_ack),
        .ba_rdy      (ba_rdy),
        .data_read   (data_read)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(input logic [21:0] exp_addr, input string name);
        int n = 0;
        while (!ba_rd && n < 20) begin
            tick();
            n++;
        end
        chk({name, " ba_rd"}, ba_rd, 1);
        chk({name, " ba_addr"}, ba_addr, exp_addr);
    endtask

    task automatic serve(input logic [15:0] w);
        $display("txn: ba_addr=%06h data_read=%04h", ba_addr, w);
        ba_ack = 1'b1;
        tick();
        ba_ack = 1'b0;
        chk("ack drops ba_rd", ba_rd, 0);
        ba_rdy    = 1'b1;
        data_read = w;
        tick();
        ba_rdy = 1'b0;
    endtask

    task automatic do_reset();
        snd_cs = 1'b0;
        pcm_cs = 1'b0;
        ba_ack = 1'b0;
        ba_rdy = 1'b0;
        downloading = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h0200, 1'b1, 16'h0031, 1'b1, 8'h34, 1'b1, 8'hCA};
        vecs[1] = '{1'b1, 16'h0201, 1'b1, 16'h0030, 1'b1, 8'h12, 1'b1, 8'hFE};
        vecs[2] = '{1'b0, 16'h0201, 1'b1, 16'h0031, 1'b0, 8'h12, 1'b1, 8'hCA};
        vecs[3] = '{1'b1, 16'h0200, 1'b0, 16'h0030, 1'b1, 8'h34, 1'b0, 8'hFE};
        vecs[4] = '{1'b0, 16'h0200, 1'b0, 16'h0031, 1'b0, 8'h34, 1'b0, 8'hCA};
        vecs[5] = '{1'b1, 16'h0201, 1'b1, 16'h0031, 1'b1, 8'h12, 1'b1, 8'hCA};

        rst = 1'b1;
        downloading = 1'b0;
        snd_cs = 1'b0;
        snd_addr = 16'h0000;
        pcm_cs = 1'b0;
        pcm_addr = 16'h0000;
        ba_ack = 1'b0;
        ba_rdy = 1'b0;
        data_read = 16'h0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset ba_rd", ba_rd, 0);
        chk("reset ba_addr", ba_addr, 22'h0);
        chk("reset snd_ok", snd_ok, 0);
        chk("reset pcm_ok", pcm_ok, 0);
        chk("reset snd_data", snd_data, 8'h00);
        chk("reset pcm_data", pcm_data, 8'h00);

        // Basic miss, fill and hit on the other byte of the same word
        snd_cs = 1'b1;
        snd_addr = 16'h0123;
        wait_rd(22'h000091, "t1 miss");
        serve(16'hBEEF);
        tick();
        chk("t1 snd_ok", snd_ok, 1);
        chk("t1 snd_data odd", snd_data, 8'hBE);
        snd_addr = 16'h0122;
        tick();
        chk("t1 hit snd_ok", snd_ok, 1);
        chk("t1 hit snd_data even", snd_data, 8'hEF);
        chk("t1 hit no ba_rd", ba_rd, 0);

        // Round-robin arbitration
        do_reset();
        snd_cs = 1'b1;
        snd_addr = 16'h0040;
        pcm_cs = 1'b1;
        pcm_addr = 16'h0010;
        wait_rd(22'h000020, "t2 tie snd first");
        serve(16'h1111);
        wait_rd(22'h008008, "t2 pcm next");
        serve(16'hA5C3);
        tick();
        chk("t2 pcm_ok", pcm_ok, 1);
        chk("t2 pcm_data", pcm_data, 8'hC3);
        chk("t2 snd_ok", snd_ok, 1);
        snd_addr = 16'h0042;
        wait_rd(22'h000021, "t2 snd alone");
        serve(16'h2222);
        snd_addr = 16'h0044;
        pcm_addr = 16'h0020;
        wait_rd(22'h008010, "t2 tie pcm first");
        serve(16'h3333);
        wait_rd(22'h000022, "t2 snd after pcm");
        serve(16'h4444);

        // Address change while waiting for data
        do_reset();
        snd_cs = 1'b1;
        snd_addr = 16'h0000;
        wait_rd(22'h000000, "t3 first");
        ba_ack = 1'b1;
        tick();
        ba_ack = 1'b0;
        snd_addr = 16'h0100;
        ba_rdy = 1'b1;
        data_read = 16'h7777;
        tick();
        ba_rdy = 1'b0;
        tick();
        chk("t3 snd_ok stale fill", snd_ok, 0);
        chk("t3 reissue ba_rd", ba_rd, 1);
        chk("t3 reissue ba_addr", ba_addr, 22'h000080);
        serve(16'h5555);
        tick();
        chk("t3 snd_ok after refill", snd_ok, 1);
        chk("t3 snd_data", snd_data, 8'h55);

        // Download pulse flushes both caches
        pcm_cs = 1'b1;
        pcm_addr = 16'h0010;
        wait_rd(22'h008008, "t4 pcm fill");
        serve(16'h9876);
        tick();
        chk("t4 snd_ok before", snd_ok, 1);
        chk("t4 pcm_ok before", pcm_ok, 1);
        downloading = 1'b1;
        tick();
        downloading = 1'b0;
        chk("t4 snd_ok flushed", snd_ok, 0);
        chk("t4 pcm_ok flushed", pcm_ok, 0);
        chk("t4 no ba_rd while downloading", ba_rd, 0);
        tick();
        chk("t4 re-miss ba_rd", ba_rd, 1);
        chk("t4 re-miss ba_addr", ba_addr, 22'h000080);
        serve(16'h5555);
        wait_rd(22'h008008, "t4 pcm re-miss");
        serve(16'h9876);

        // Asynchronous reset while waiting for ack
        snd_addr = 16'h0300;
        wait_rd(22'h000180, "t5 issue");
        #2 rst = 1'b1;
        #1;
        chk("t5 async ba_rd", ba_rd, 0);
        chk("t5 async snd_ok", snd_ok, 0);
        snd_cs = 1'b0;
        pcm_cs = 1'b0;
        #1 rst = 1'b0;
        tick();
        chk("t5 idle ba_rd", ba_rd, 0);
        chk("t5 ba_addr", ba_addr, 22'h0);
        chk("t5 snd_ok", snd_ok, 0);
        chk("t5 pcm_ok", pcm_ok, 0);
        snd_cs = 1'b1;
        tick();
        chk("t5 new issue ba_rd", ba_rd, 1);
        chk("t5 new issue ba_addr", ba_addr, 22'h000180);
        serve(16'h0000);

        // ack and rdy in the same cycle
        do_reset();
        snd_cs = 1'b1;
        snd_addr = 16'h0200;
        wait_rd(22'h000100, "t6 issue");
        ba_ack = 1'b1;
        ba_rdy = 1'b1;
        data_read = 16'h1234;
        tick();
        ba_ack = 1'b0;
        ba_rdy = 1'b0;
        chk("t6 ba_rd dropped", ba_rd, 0);
        tick();
        chk("t6 snd_ok", snd_ok, 1);
        chk("t6 snd_data", snd_data, 8'h34);
        chk("t6 back in idle", ba_rd, 0);
        pcm_cs = 1'b1;
        pcm_addr = 16'h0031;
        wait_rd(22'h008018, "t6 pcm issue");
        serve(16'hCAFE);

        // Hit table against both filled caches
        for (int i = 0; i < 6; i++) begin
            snd_cs   = vecs[i].snd_cs;
            snd_addr = vecs[i].snd_addr;
            pcm_cs   = vecs[i].pcm_cs;
            pcm_addr = vecs[i].pcm_addr;
            tick();
            $display("vec %0d: snd_ok=%0b snd_data=%02h pcm_ok=%0b pcm_data=%02h",
                     i, snd_ok, snd_data, pcm_ok, pcm_data);
            chk($sformatf("vec%0d snd_ok", i), snd_ok, vecs[i].exp_snd_ok);
            chk($sformatf("vec%0d snd_data", i), snd_data, vecs[i].exp_snd_data);
            chk($sformatf("vec%0d pcm_ok", i), pcm_ok, vecs[i].exp_pcm_ok);
            chk($sformatf("vec%0d pcm_data", i), pcm_data, vecs[i].exp_pcm_data);
            chk($sformatf("vec%0d ba_rd", i), ba_rd, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
